pc_call_stack: RTL and testbench
================================

Name: pc_call_stack

Overview:
- Parametrised hardware return-address stack for the pipelined core. Successor to the fixed single-purpose call stack.
- The fetch stage pushes the return PC (PC+1) on CALL and pops on RET.
- Adds configurable width/depth, full/empty/count status, an overflow mode, sticky error flags, and a one-level checkpoint/restore so flushed speculative calls and returns can be undone.

Parameters:
- ADDR_W, 12, width of stored return address.
- DEPTH, 8, number of entries; must be a power of two, >= 2.
- OVF_MODE, 0, 0 = saturate (push when full is dropped); 1 = circular (push when full overwrites the oldest entry).
- PTR_W (localparam), $clog2(DEPTH), pointer width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- push  input  1  push push_addr this cycle.
- pop  input  1  pop top entry this cycle.
- push_addr  input  ADDR_W  return address to push.
- top_addr  output  ADDR_W  current top entry (combinational).
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  PTR_W+1  number of valid entries.
- chk_save  input  1  snapshot sp/count into the shadow registers.
- chk_restore  input  1  restore sp/count from the shadow registers.
- err_clr  input  1  clear the sticky error flags.
- ovf_err  output  1  sticky; a push occurred while full.
- unf_err  output  1  sticky; a pop occurred while empty.

Behaviour:
- State:
  - mem[DEPTH] of ADDR_W.
  - sp (PTR_W): next write slot.
  - cnt (PTR_W+1).
  - shadow sp_s/cnt_s.
  - ovf_err, unf_err.
- Reset (rst=0 at a clk edge):
  - sp=0, cnt=0, sp_s=0, cnt_s=0, ovf_err=0, unf_err=0.
  - mem contents are not reset.
  - Outputs after reset: top_addr=0, empty=1, full=0, count=0.
  - Reset overrides all other inputs in that cycle.
- top_addr = mem[sp-1] (modulo DEPTH) when cnt>0, else 0.
  - Zero-latency read; updates become visible the cycle after the edge.
- Priority per edge: rst > chk_restore > push/pop.
- chk_restore=1: sp<=sp_s, cnt<=cnt_s; push/pop ignored that cycle; mem unchanged.
  - Entries overwritten since the save are not recovered; this is an accepted limitation.
- push=1, pop=0:
  - cnt<DEPTH: mem[sp]<=push_addr, sp<=sp+1, cnt<=cnt+1.
  - cnt==DEPTH, OVF_MODE=0: no state change, ovf_err<=1.
  - cnt==DEPTH, OVF_MODE=1: mem[sp]<=push_addr, sp<=sp+1 (wraps), cnt stays DEPTH, ovf_err<=1.
- pop=1, push=0:
  - cnt>0: sp<=sp-1, cnt<=cnt-1.
  - cnt==0: no state change, unf_err<=1.
- push=1, pop=1 (tail call / replace top):
  - cnt>0: mem[sp-1]<=push_addr; sp and cnt unchanged.
  - cnt==0: behaves as push only; no underflow flagged.
- chk_save=1: sp_s<=sp, cnt_s<=cnt, using pre-edge values.
  - With chk_restore in the same cycle, restore wins and the shadow is unchanged.
- Pointer arithmetic is modulo DEPTH (natural PTR_W wrap).
- err_clr=1 clears both flags.
  - A new error in the same cycle takes precedence; that flag is set.
- full/empty/count are derived from cnt only (combinational).

Optional Feature:
- Macro: CALL_STACK_HWM_EN.
- Defined:
  - Adds output hwm[PTR_W+1], the maximum cnt reached since reset or the last err_clr.
  - Updated on the edge where cnt is written: hwm<=max(hwm, new cnt).
  - Reset value 0.
  - err_clr sets hwm to the current post-edge cnt.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Reset/basic (DEPTH=8, ADDR_W=12): hold rst=0 for 2 cycles -> top_addr=0, empty=1, count=0, errors 0. Then push 0x005, 0x07F, 0xA10 -> count=3, top_addr=0xA10. Three pops -> top_addr 0x07F, then 0x005, then 0 with empty=1.
- Overflow, OVF_MODE=0, DEPTH=4: push 0x001..0x005 -> count=4, full=1, top_addr=0x004, ovf_err=1. Four pops yield 0x004, 0x003, 0x002, 0x001.
- Overflow, OVF_MODE=1, DEPTH=4: push 0x001..0x005 -> count=4, top_addr=0x005, ovf_err=1. Pops yield 0x005, 0x004, 0x003, 0x002, then empty.
- Underflow and error clear: pop on empty -> unf_err=1, count=0. Then err_clr=1 together with another pop on empty -> unf_err stays 1. Then err_clr alone -> unf_err=0.
- Replace/simultaneous: stack [0x010, 0x020]; push=pop=1 with 0x0FF -> count=2, top_addr=0x0FF. On empty, push=pop=1 with 0x033 -> count=1, top_addr=0x033, unf_err=0.
- Checkpoint/restore and mid-operation reset:
  - Stack [0x100]; chk_save; push 0x200; pop; pop -> empty.
  - chk_restore -> count=1, top_addr=0x100.
  - chk_restore with push 0x300 in the same cycle -> push ignored, count=1.
  - rst=0 while count=1 and push=1 -> count=0, empty=1.
  - With CALL_STACK_HWM_EN: hwm=2 before the reset, 0 after it.

Source files
------------

// File: rtl/pc_call_stack.sv
// Parametrised return-address stack with status, overflow modes, sticky errors
// and one-level checkpoint/restore. Define CALL_STACK_HWM_EN to add the hwm output.
module pc_call_stack #(
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    count,
    input  logic              chk_save,
    input  logic              chk_restore,
    input  logic              err_clr,
    output logic              ovf_err,
    output logic              unf_err
`ifdef CALL_STACK_HWM_EN
    ,
    output logic [PTR_W:0]    hwm
`endif
);

    localparam logic [PTR_W-1:0] SP_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] SP_ZERO  = PTR_W'(0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d, sp_s_q, sp_s_d;
    logic [PTR_W:0]    cnt_q, cnt_d, cnt_s_q, cnt_s_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              mem_we_s;
    logic [PTR_W-1:0]  mem_waddr_s;
    logic              ovf_set_s, unf_set_s;
`ifdef CALL_STACK_HWM_EN
    logic [PTR_W:0]    hwm_q, hwm_d;
`endif

    // Next-state: restore beats push/pop; save uses pre-edge pointers.
    always_comb begin
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        sp_s_d      = sp_s_q;
        cnt_s_d     = cnt_s_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = sp_q;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        if (chk_restore) begin
            sp_d  = sp_s_q;
            cnt_d = cnt_s_q;
        end else begin
            if (chk_save) begin
                sp_s_d  = sp_q;
                cnt_s_d = cnt_q;
            end else begin
                sp_s_d  = sp_s_q;
                cnt_s_d = cnt_s_q;
            end
            case ({push, pop})
                2'b10, 2'b11: begin
                    if (push && pop && (cnt_q != CNT_ZERO)) begin
                        // Tail call: replace the top entry in place.
                        mem_we_s    = 1'b1;
                        mem_waddr_s = sp_q - SP_ONE;
                    end else if (cnt_q != CNT_FULL) begin
                        mem_we_s = 1'b1;
                        sp_d     = sp_q + SP_ONE;
                        cnt_d    = cnt_q + CNT_ONE;
                    end else begin
                        ovf_set_s = 1'b1;
                        if (OVF_MODE == 1) begin
                            mem_we_s = 1'b1;
                            sp_d     = sp_q + SP_ONE;
                        end else begin
                            mem_we_s = 1'b0;
                        end
                    end
                end
                2'b01: begin
                    if (cnt_q != CNT_ZERO) begin
                        sp_d  = sp_q - SP_ONE;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        unf_set_s = 1'b1;
                    end
                end
                default: begin
                    mem_we_s = 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags: a fresh error wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
            unf_d = unf_q;
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end
        if (unf_set_s) begin
            unf_d = 1'b1;
        end else begin
            unf_d = unf_d;
        end
    end

`ifdef CALL_STACK_HWM_EN
    // High-water mark tracks the post-edge count; err_clr rebases it.
    always_comb begin
        hwm_d = hwm_q;
        if (err_clr) begin
            hwm_d = cnt_d;
        end else if (cnt_d > hwm_q) begin
            hwm_d = cnt_d;
        end else begin
            hwm_d = hwm_q;
        end
    end
`endif

    // Pointer, count, shadow and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q    <= SP_ZERO;
            cnt_q   <= CNT_ZERO;
            sp_s_q  <= SP_ZERO;
            cnt_s_q <= CNT_ZERO;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`ifdef CALL_STACK_HWM_EN
            hwm_q   <= CNT_ZERO;
`endif
        end else begin
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            sp_s_q  <= sp_s_d;
            cnt_s_q <= cnt_s_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`ifdef CALL_STACK_HWM_EN
            hwm_q   <= hwm_d;
`endif
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (rst && mem_we_s) begin
            mem_q[mem_waddr_s] <= push_addr;
        end
    end

    // Zero-latency top-of-stack read and status decode.
    always_comb begin
        top_addr = {ADDR_W{1'b0}};
        if (cnt_q != CNT_ZERO) begin
            top_addr = mem_q[sp_q - SP_ONE];
        end else begin
            top_addr = {ADDR_W{1'b0}};
        end
    end

    assign empty   = (cnt_q == CNT_ZERO);
    assign full    = (cnt_q == CNT_FULL);
    assign count   = cnt_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`ifdef CALL_STACK_HWM_EN
    assign hwm     = hwm_q;
`endif

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: three configurations driven in lockstep and compared
// against an array-based reference model, with directed and random phases.
module tb_pc_call_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0, pop = 1'b0;
    logic        chk_save = 1'b0, chk_restore = 1'b0, err_clr = 1'b0;
    logic [11:0] push_addr = 12'd0;

    logic [11:0] top0, top1, top2;
    logic        emp0, emp1, emp2, ful0, ful1, ful2;
    logic        ovf0, ovf1, ovf2, unf0, unf1, unf2;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1, cnt2;
`ifdef CALL_STACK_HWM_EN
    logic [3:0]  hwm0;
    logic [2:0]  hwm1, hwm2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int dep  [3] = '{8, 4, 4};
    int mode [3] = '{0, 0, 1};
    int m_mem [3][8];
    int m_sp [3], m_cnt [3], m_sps [3], m_cnts [3], m_ovf [3], m_unf [3], m_hwm [3];

    always #5 clk = ~clk;

    pc_call_stack #(.ADDR_W(12), .DEPTH(8), .OVF_MODE(0)) u0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
        .top_addr(top0), .empty(emp0), .full(ful0), .count(cnt0),
        .chk_save(chk_save), .chk_restore(chk_restore), .err_clr(err_clr),
        .ovf_err(ovf0), .unf_err(unf0)
`ifdef CALL_STACK_HWM_EN
        , .hwm(hwm0)
`endif
    );

    pc_call_stack #(.ADDR_W(12), .DEPTH(4), .OVF_MODE(0)) u1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
        .top_addr(top1), .empty(emp1), .full(ful1), .count(cnt1),
        .chk_save(chk_save), .chk_restore(chk_restore), .err_clr(err_clr),
        .ovf_err(ovf1), .unf_err(unf1)
`ifdef CALL_STACK_HWM_EN
        , .hwm(hwm1)
`endif
    );

    pc_call_stack #(.ADDR_W(12), .DEPTH(4), .OVF_MODE(1)) u2 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
        .top_addr(top2), .empty(emp2), .full(ful2), .count(cnt2),
        .chk_save(chk_save), .chk_restore(chk_restore), .err_clr(err_clr),
        .ovf_err(ovf2), .unf_err(unf2)
`ifdef CALL_STACK_HWM_EN
        , .hwm(hwm2)
`endif
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one stack instance for the edge just taken.
    task automatic model_edge(input int i);
        int d;
        bit new_ovf, new_unf;
        d = dep[i];
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (!rst) begin
            m_sp[i] = 0; m_cnt[i] = 0; m_sps[i] = 0; m_cnts[i] = 0;
            m_ovf[i] = 0; m_unf[i] = 0; m_hwm[i] = 0;
            return;
        end
        if (chk_restore) begin
            m_sp[i]  = m_sps[i];
            m_cnt[i] = m_cnts[i];
        end else begin
            if (chk_save) begin
                m_sps[i]  = m_sp[i];
                m_cnts[i] = m_cnt[i];
            end
            if (push && pop && m_cnt[i] > 0) begin
                m_mem[i][(m_sp[i] + d - 1) % d] = int'(push_addr);
            end else if (push) begin
                if (m_cnt[i] < d) begin
                    m_mem[i][m_sp[i]] = int'(push_addr);
                    m_sp[i] = (m_sp[i] + 1) % d;
                    m_cnt[i]++;
                end else begin
                    new_ovf = 1'b1;
                    if (mode[i] == 1) begin
                        m_mem[i][m_sp[i]] = int'(push_addr);
                        m_sp[i] = (m_sp[i] + 1) % d;
                    end
                end
            end else if (pop) begin
                if (m_cnt[i] > 0) begin
                    m_sp[i] = (m_sp[i] + d - 1) % d;
                    m_cnt[i]--;
                end else begin
                    new_unf = 1'b1;
                end
            end
        end
        if (err_clr) begin
            m_ovf[i] = 0;
            m_unf[i] = 0;
            m_hwm[i] = m_cnt[i];
        end
        if (m_cnt[i] > m_hwm[i]) m_hwm[i] = m_cnt[i];
        if (new_ovf) m_ovf[i] = 1;
        if (new_unf) m_unf[i] = 1;
    endtask

    function automatic int exp_top(input int i);
        if (m_cnt[i] == 0) return 0;
        return m_mem[i][(m_sp[i] + dep[i] - 1) % dep[i]];
    endfunction

    task automatic check_all();
        logic [31:0] ot, oc, oh;
        logic oe, of, oo, ou;
        for (int i = 0; i < 3; i++) begin
            oh = 32'd0;
            case (i)
                0: begin ot = 32'(top0); oc = 32'(cnt0); oe = emp0; of = ful0; oo = ovf0; ou = unf0; end
                1: begin ot = 32'(top1); oc = 32'(cnt1); oe = emp1; of = ful1; oo = ovf1; ou = unf1; end
                default: begin ot = 32'(top2); oc = 32'(cnt2); oe = emp2; of = ful2; oo = ovf2; ou = unf2; end
            endcase
`ifdef CALL_STACK_HWM_EN
            case (i)
                0: oh = 32'(hwm0);
                1: oh = 32'(hwm1);
                default: oh = 32'(hwm2);
            endcase
            cmp($sformatf("u%0d.hwm", i), oh, 32'(m_hwm[i]));
`endif
            cmp($sformatf("u%0d.top", i), ot, 32'(exp_top(i)));
            cmp($sformatf("u%0d.count", i), oc, 32'(m_cnt[i]));
            cmp($sformatf("u%0d.empty", i), 32'(oe), 32'(m_cnt[i] == 0));
            cmp($sformatf("u%0d.full", i), 32'(of), 32'(m_cnt[i] == dep[i]));
            cmp($sformatf("u%0d.ovf", i), 32'(oo), 32'(m_ovf[i]));
            cmp($sformatf("u%0d.unf", i), 32'(ou), 32'(m_unf[i]));
        end
    endtask

    task automatic step(input bit r_n, input bit pu, input bit po, input logic [11:0] a,
                        input bit sv, input bit rs, input bit cl);
        rst = r_n; push = pu; pop = po; push_addr = a;
        chk_save = sv; chk_restore = rs; err_clr = cl;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        check_all();
    endtask

    initial begin
        // Reset held two cycles with push asserted to show reset dominates.
        step(1'b0, 1'b1, 1'b0, 12'h111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        cmp("rst.top", 32'(top0), 32'h0);
        cmp("rst.empty", 32'(emp0), 32'h1);

        // Basic push/pop.
        step(1'b1, 1'b1, 1'b0, 12'h005, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'h07F, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'hA10, 1'b0, 1'b0, 1'b0);
        cmp("basic.count", 32'(cnt0), 32'd3);
        cmp("basic.top", 32'(top0), 32'hA10);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        cmp("basic.pop1", 32'(top0), 32'h07F);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        cmp("basic.pop2", 32'(top0), 32'h005);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        cmp("basic.pop3", 32'(top0), 32'h000);

        // Overflow in both modes on the 4-deep instances.
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b1, 1'b0, 12'(k), 1'b0, 1'b0, 1'b0);
        cmp("sat.top", 32'(top1), 32'h004);
        cmp("sat.full", 32'(ful1), 32'h1);
        cmp("sat.ovf", 32'(ovf1), 32'h1);
        cmp("circ.top", 32'(top2), 32'h005);
        cmp("circ.count", 32'(cnt2), 32'd4);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        cmp("sat.pop1", 32'(top1), 32'h003);
        cmp("circ.pop1", 32'(top2), 32'h004);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);

        // Underflow and error clear.
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        cmp("unf.set", 32'(unf0), 32'h1);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1);
        cmp("unf.clr_vs_new", 32'(unf0), 32'h1);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        cmp("unf.clr", 32'(unf0), 32'h0);

        // Replace top, then push+pop on empty.
        step(1'b1, 1'b1, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'h020, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 12'h0FF, 1'b0, 1'b0, 1'b0);
        cmp("repl.top", 32'(top0), 32'h0FF);
        cmp("repl.count", 32'(cnt0), 32'd2);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 12'h033, 1'b0, 1'b0, 1'b0);
        cmp("pp_empty.top", 32'(top0), 32'h033);
        cmp("pp_empty.unf", 32'(unf0), 32'h0);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1);

        // Checkpoint/restore and mid-operation reset.
        step(1'b1, 1'b1, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        cmp("restore.count", 32'(cnt0), 32'd1);
        cmp("restore.top", 32'(top0), 32'h100);
        step(1'b1, 1'b1, 1'b0, 12'h300, 1'b0, 1'b1, 1'b0);
        cmp("restore_push.count", 32'(cnt0), 32'd1);
        step(1'b0, 1'b1, 1'b0, 12'h3AA, 1'b0, 1'b0, 1'b0);
        cmp("midrst.empty", 32'(emp0), 32'h1);

        // Random phase against the model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                 12'($urandom),
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
